// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised sequence detector.
package seq_detect_pkg;

  localparam int unsigned MaxPatW = 16;

  function automatic int unsigned state_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic logic pat_bit(input logic [MaxPatW-1:0] pattern, input int unsigned pos);
    logic [MaxPatW-1:0] w_tmp;
    w_tmp = pattern >> pos;
    return w_tmp[0];
  endfunction

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, then b).
  function automatic int unsigned kmp_next(input logic [MaxPatW-1:0] pattern,
                                           input int unsigned pat_w,
                                           input int unsigned k,
                                           input logic b);
    int unsigned best;
    int unsigned idx;
    logic        ok;
    logic        s_bit;
    best = 0;
    for (int unsigned j = 1; j <= MaxPatW; j++) begin
      if (j <= pat_w && j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MaxPatW; i++) begin
          if (i < j) begin
            idx   = k + 1 - j + i;
            s_bit = (idx < k) ? pat_bit(pattern, pat_w - 1 - idx) : b;
            if (s_bit != pat_bit(pattern, pat_w - 1 - i)) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_ns.sv
// Combinational next-state lookup; the table is built from PATTERN at elaboration.
module seq_detect_ns
  import seq_detect_pkg::*;
#(
  parameter int unsigned       PAT_W   = 3,
  parameter logic [PAT_W-1:0]  PATTERN = 3'b101,
  parameter int unsigned       OVERLAP = 1,
  parameter int unsigned       SW      = state_w(PAT_W)
) (
  input  logic [SW-1:0] i_state,
  input  logic          i_in,
  output logic [SW-1:0] o_next
);

  logic [SW-1:0] w_tab [2*(PAT_W+1)];

  for (genvar k = 0; k <= PAT_W; k++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_b
      // Non-overlapping mode restarts from the empty prefix after a full match.
      localparam int unsigned SrcK = (k == PAT_W && OVERLAP == 0) ? 0 : k;
      localparam int unsigned Nxt  = kmp_next(MaxPatW'(PATTERN), PAT_W, SrcK, 1'(b));
      assign w_tab[2*k+b] = SW'(Nxt);
    end
  end

  always_comb begin
    o_next = '0;
    if (i_state <= SW'(PAT_W)) o_next = w_tab[{i_state, i_in}];
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector (Moore out, prefix progress, saturating match count).
// Define SEQ_DETECT_COUNT_EN to build the match counter; otherwise match_count is tied to 0.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int unsigned      OVERLAP = 1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       clr_count,
  output logic                       out,
  output logic [$clog2(PAT_W+1)-1:0] progress,
  output logic [CNT_W-1:0]           match_count
);

  localparam int unsigned StW = state_w(PAT_W);

  logic [StW-1:0] r_state;
  logic [StW-1:0] w_state_d;
  logic [StW-1:0] w_ns_kmp;
  logic           w_hit;

  seq_detect_ns #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (StW)
  ) u_ns (
    .i_state (r_state),
    .i_in    (in),
    .o_next  (w_ns_kmp)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= '0;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    if (in_valid) w_state_d = w_ns_kmp;
  end

  always_comb begin
    out      = (r_state == StW'(PAT_W));
    progress = r_state;
  end

  assign w_hit = in_valid && (w_ns_kmp == StW'(PAT_W));

`ifdef SEQ_DETECT_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge areset) begin
    if (areset)                     r_count <= '0;
    else if (clr_count)             r_count <= '0;
    else if (w_hit && ~&r_count)    r_count <= r_count + 1'b1;
  end

  assign match_count = r_count;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = clr_count ^ w_hit;
  assign match_count  = '0;
`endif

endmodule
